// File: rtl/timer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_seq_pkg
//  Description : Shared types and default sizes for the timer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_seq_pkg;

    localparam int c_DW    = 10;  // interval width, matches timer data
    localparam int c_DEPTH = 4;   // interval FIFO entries
    localparam int c_CW    = 8;   // expiry counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : timer_seq_fifo
//  Description : Synchronous interval FIFO with count-based full/empty and a
//                synchronous flush. Read data is the current head (no bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_seq_fifo
    import timer_seq_pkg::*;
#(
    parameter int DW    = c_DW,
    parameter int DEPTH = c_DEPTH
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == c_FULL);
    assign empty  = (r_count == '0);
    assign rdata  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
        end
    end

    // Storage write; a push coincident with a flush is dropped.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_sequencer
//  Description : Queues interval values, loads them into the down-counting
//                timer one at a time, and reports/counts each expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int DW    = c_DW,
    parameter int DEPTH = c_DEPTH,
    parameter int CW    = c_CW
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          repeat_en,
    input  logic          abort,
    output logic          load,
    output logic [DW-1:0] data,
    input  logic          tc,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] done_count
);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_pop;
    logic          w_expire;
    logic          w_load_nxt;
    logic          w_busy_nxt;
    logic          w_full;
    logic          w_empty;
    logic [DW-1:0] w_head;

    logic          r_load;
    logic [DW-1:0] r_data;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_done_count;

    timer_seq_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .flush    (abort),
        .push     (in_valid),
        .pop      (w_pop),
        .wdata    (in_data),
        .rdata    (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign in_ready   = !w_full;
    assign load       = r_load;
    assign data       = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_count = r_done_count;

    // State register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pop decision; abort overrides every transition.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // tc still reflects the previous interval here
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (tc) begin
                    w_expire = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_LOAD;
                    end else if (repeat_en) begin
                        w_next_state = ST_LOAD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next_state = ST_IDLE;
            w_pop        = 1'b0;
            w_expire     = 1'b0;
        end
    end

    // Output decode from the upcoming state so outputs register alongside it.
    always_comb begin
        w_load_nxt = (w_next_state == ST_LOAD);
        w_busy_nxt = (w_next_state != ST_IDLE);
    end

    // Registered outputs: load/busy, interval data, expiry pulse and counter.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_load <= w_load_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_expire;
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_expire) begin
                r_done_count <= r_done_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_sequencer
//  Description : Scoreboard bench for timer_sequencer driving a behavioural
//                10-bit down-counting timer. Expiry counter narrowed to 2 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_sequencer;

    localparam int c_DW    = 10;
    localparam int c_DEPTH = 4;
    localparam int c_CW    = 2;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              areset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [c_DW-1:0]   in_data = '0;
    logic              repeat_en = 1'b0;
    logic              abort = 1'b0;
    logic              load;
    logic [c_DW-1:0]   data;
    logic              tc;
    logic              busy;
    logic              done;
    logic [c_CW-1:0]   done_count;

    logic [c_DW-1:0]   tmr = '0;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                model_cnt = 0;
    exp_t              exp_load[$];
    exp_t              exp_done[$];

    timer_sequencer #(
        .DW    (c_DW),
        .DEPTH (c_DEPTH),
        .CW    (c_CW)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .repeat_en  (repeat_en),
        .abort      (abort),
        .load       (load),
        .data       (data),
        .tc         (tc),
        .busy       (busy),
        .done       (done),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // Behavioural down-counting timer fed by the sequencer.
    always @(posedge clk) begin
        if (load) begin
            tmr <= data;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end
    assign tc = (tmr == '0);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every load/done the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (areset_n) begin
            if (load) begin
                chk("load_pending", int'(exp_load.size() > 0), 1);
                if (exp_load.size() > 0) begin
                    exp_t e;
                    e = exp_load.pop_front();
                    chk("load_data", int'(data), e.val);
                    chk("load_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                chk("done_pending", int'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) begin
                    exp_t e;
                    e = exp_done.pop_front();
                    chk("done_count", int'(done_count), e.val);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Offer one interval; returns the edge number at which it was accepted.
    task automatic push(input int v, output int p);
        logic rdy;
        rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = c_DW'(v);
        for (int k = 0; k < 100; k++) begin
            rdy = in_ready;
            tick();
            if (rdy) break;
        end
        chk("push_accepted", int'(rdy), 1);
        p = cyc;
    endtask

    task automatic add_load(input int v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_load.push_back(e);
    endtask

    task automatic add_done(input int c);
        exp_t e;
        model_cnt = (model_cnt + 1) % (1 << c_CW);
        e.val = model_cnt;
        e.cyc = c;
        exp_done.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_load"},       int'(load), 0);
        chk({tag, "_data"},       int'(data), 0);
        chk({tag, "_busy"},       int'(busy), 0);
        chk({tag, "_done"},       int'(done), 0);
        chk({tag, "_done_count"}, int'(done_count), 0);
        chk({tag, "_in_ready"},   int'(in_ready), 1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (exp_load.size() == 0 && exp_done.size() == 0) break;
            tick();
        end
        chk({tag, "_loads_left"}, exp_load.size(), 0);
        chk({tag, "_dones_left"}, exp_done.size(), 0);
    endtask

    initial begin
        int p;
        int q;

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");
        areset_n = 1'b1;
        tick();

        // Single interval N=3: load 1 edge after accept, done 5 after load
        push(3, p);
        in_valid = 1'b0;
        add_load(3, p + 1);
        add_done(p + 6);
        wait_until(p + 8);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done_count", int'(done_count), model_cnt);

        // Back-to-back 2, 0, 5: loads 4 then 2 cycles apart
        push(2, p);
        add_load(2, p + 1);
        push(0, q);
        push(5, q);
        in_valid = 1'b0;
        add_load(0, p + 5);
        add_load(5, p + 7);
        add_done(p + 5);
        add_done(p + 7);
        add_done(p + 14);
        wait_until(p + 16);
        chk("t2_busy", int'(busy), 0);
        chk("t2_done_count", int'(done_count), model_cnt);

        // FIFO fill while a long interval runs; fifth entry held off
        push(20, p);
        add_load(20, p + 1);
        push(1, q);
        push(2, q);
        push(3, q);
        push(0, q);
        chk("t3_in_ready_full", int'(in_ready), 0);
        add_done(p + 23);
        add_load(1, p + 23);
        add_done(p + 26);
        add_load(2, p + 26);
        add_done(p + 30);
        add_load(3, p + 30);
        add_done(p + 35);
        add_load(0, p + 35);
        add_done(p + 37);
        add_load(1, p + 37);
        add_done(p + 40);
        push(1, q);
        in_valid = 1'b0;
        chk("t3_held_accept_cycle", q, p + 24);
        wait_until(p + 42);
        chk("t3_busy", int'(busy), 0);
        drain("t3");

        // Repeat mode with N=1, dropped after the second reload
        repeat_en = 1'b1;
        push(1, p);
        in_valid = 1'b0;
        add_load(1, p + 1);
        add_load(1, p + 4);
        add_load(1, p + 7);
        add_done(p + 4);
        add_done(p + 7);
        add_done(p + 10);
        wait_until(p + 8);
        repeat_en = 1'b0;
        wait_until(p + 13);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done_count", int'(done_count), model_cnt);

        // Abort in WAIT with two entries queued and a push in the abort cycle
        push(10, p);
        add_load(10, p + 1);
        push(1, q);
        push(1, q);
        in_valid = 1'b0;
        wait_until(p + 5);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'd7;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_load", int'(load), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_data_kept", int'(data), 10);
        chk("t5_done_count", int'(done_count), model_cnt);
        repeat (25) tick();
        chk("t5_busy_later", int'(busy), 0);
        drain("t5");

        // Counter wrap: five N=0 intervals after a fresh reset
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        model_cnt = 0;
        tick();
        push(0, p);
        for (int k = 0; k < 5; k++) begin
            add_load(0, p + 1 + 2 * k);
            add_done(p + 3 + 2 * k);
        end
        for (int k = 0; k < 4; k++) push(0, q);
        in_valid = 1'b0;
        wait_until(p + 13);
        chk("t6_done_count_wrap", int'(done_count), 1);
        drain("t6");

        // Asynchronous reset mid-WAIT with an entry still queued
        push(10, p);
        add_load(10, p + 1);
        push(3, q);
        in_valid = 1'b0;
        wait_until(p + 5);
        #3;
        areset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_cnt = 0;
        tick();
        areset_n = 1'b1;
        repeat (30) tick();
        chk("t6_busy_after_reset", int'(busy), 0);
        chk("t6_done_count_after_reset", int'(done_count), 0);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
